// File: rtl/aduna_seriala_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master side issues operations; the slave side (the adder) returns results.
interface aduna_seriala_if #(
  parameter int unsigned WIDTH = 8
) ();

  // Request side, sampled by the adder only on an accepting start edge.
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  // Status and the last completed result.
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, x, y,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, x, y,
    output busy, done, s, c_out, ovf
  );

endinterface

// File: rtl/aduna_seriala.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB first, over
// WIDTH/DIGIT cycles. Results are published only when an operation completes,
// so s/c_out/ovf always show the last finished operation.
module aduna_seriala #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic              clk,
  input logic              rst_n,
  aduna_seriala_if.slave   bus
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("aduna_seriala: WIDTH must be in 2..64");
  end
  if ((DIGIT == 0) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("aduna_seriala: DIGIT must divide WIDTH exactly");
  end

  localparam int unsigned NumCyc = WIDTH / DIGIT;
  // Wide enough to hold NumCyc itself, so the counter never wraps mid-operation.
  localparam int unsigned CntW   = $clog2(NumCyc + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // remaining x digits, consumed from bit 0
  logic [WIDTH-1:0] b_q, b_d;        // remaining (possibly inverted) y digits
  logic [WIDTH-1:0] acc_q, acc_d;    // partial sum, filled from the top down
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   dig_sum;
  logic             msb_cin;
  logic             last_digit;
  logic [WIDTH-1:0] acc_shift;

  // One DIGIT-wide slice of the ripple adder; bit DIGIT is the carry out.
  assign dig_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};

  // Carry into the top bit of this digit, recovered from its sum bit.
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];

  assign last_digit = (cnt_q == CntW'(NumCyc - 1));

  // New digit enters at the top; after NumCyc shifts the LSB digit sits at bit 0.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Next-state and datapath update; every register holds unless told otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          // Subtraction is x + ~y + 1: invert y and seed the carry with 1.
          a_d     = bus.x;
          b_d     = bus.sub ? ~bus.y : bus.y;
          carry_d = bus.sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        // start is deliberately not looked at here.
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_sum[DIGIT];
        cnt_d   = cnt_q + CntW'(1);
        if (last_digit) begin
          s_d     = acc_shift;
          c_out_d = dig_sum[DIGIT];
          ovf_d   = dig_sum[DIGIT] ^ msb_cin;
          state_d = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status is decoded straight from the state so reset clears it without a clock.
  always_comb begin
    bus.busy  = (state_q == StRun);
    bus.done  = (state_q == StDone);
    bus.s     = s_q;
    bus.c_out = c_out_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_aduna_seriala.sv
// Bench for aduna_seriala: a 4-bit bit-serial instance and an 8-bit
// nibble-serial instance share clock and reset. Expected results are queued
// when an operation is launched and compared when the instance pulses done.
module tb_aduna_seriala;

  localparam int NCYC4 = 4;
  localparam int NCYC8 = 2;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        sub;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  logic [63:0] last_s4 = '0, last_s8 = '0;
  logic        last_c4 = 1'b0, last_c8 = 1'b0, last_v4 = 1'b0, last_v8 = 1'b0;

  vec_t vecs[8];

  aduna_seriala_if #(.WIDTH(4)) b4 ();
  aduna_seriala_if #(.WIDTH(8)) b8 ();

  aduna_seriala #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  aduna_seriala #(.WIDTH(8), .DIGIT(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic written in terms of signed operand signs.
  function automatic exp_t model(input int w, input logic sub, input logic [63:0] x,
                                 input logic [63:0] y);
    exp_t        r;
    logic [63:0] mask, yy, s;
    logic [64:0] full;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    yy    = (sub ? ~y : y) & mask;
    full  = {1'b0, x & mask} + {1'b0, yy} + 65'(sub);
    s     = full[63:0] & mask;
    r.s   = s;
    r.c   = full[w];
    r.v   = sub ? ((x[w-1] != y[w-1]) && (s[w-1] != x[w-1]))
                : ((x[w-1] == y[w-1]) && (s[w-1] != x[w-1]));
    r.cyc = 0;
    return r;
  endfunction

  // Launch one operation; the expectation is queued right after the accepting edge.
  task automatic drive(input int which, input logic sub, input logic [63:0] x,
                       input logic [63:0] y, input exp_t e);
    if (which == 4) begin
      b4.sub = sub; b4.x = x[3:0]; b4.y = y[3:0]; b4.start = 1'b1;
    end else begin
      b8.sub = sub; b8.x = x[7:0]; b8.y = y[7:0]; b8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    e.cyc = cyc;
    if (which == 4) begin
      q4.push_back(e);
      b4.start = 1'b0; b4.x = 4'($urandom); b4.y = 4'($urandom); b4.sub = 1'($urandom);
    end else begin
      q8.push_back(e);
      b8.start = 1'b0; b8.x = 8'($urandom); b8.y = 8'($urandom); b8.sub = 1'($urandom);
    end
  endtask

  // Wait (bounded) until the queued results are consumed; counts busy cycles seen.
  task automatic wait_drain(input int which, output int bc);
    int n;
    bc = 0;
    n  = 0;
    while (n < 12 && ((which == 4) ? q4.size() : q8.size()) != 0) begin
      @(negedge clk);
      if ((which == 4) ? b4.busy : b8.busy) bc++;
      #1;
      n++;
    end
    if (which == 4) begin
      check("drain4", 64'(q4.size()), 64'd0);
      q4.delete();
    end else begin
      check("drain8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("excl4", 64'(b4.busy & b4.done), 64'd0);
      if (b4.done) begin
        if (q4.size() == 0) begin
          check("spurious_done4", 64'(b4.done), 64'd0);
        end else begin
          e4 = q4.pop_front();
          check("s4", 64'(b4.s), e4.s);
          check("c_out4", 64'(b4.c_out), 64'(e4.c));
          check("ovf4", 64'(b4.ovf), 64'(e4.v));
          check("latency4", 64'(cyc - e4.cyc), 64'(NCYC4));
          last_s4 = e4.s; last_c4 = e4.c; last_v4 = e4.v;
        end
      end else begin
        check("hold4", {61'd0, b4.s[3:0] === last_s4[3:0], b4.c_out, b4.ovf},
              {61'd0, 1'b1, last_c4, last_v4});
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("excl8", 64'(b8.busy & b8.done), 64'd0);
      if (b8.done) begin
        if (q8.size() == 0) begin
          check("spurious_done8", 64'(b8.done), 64'd0);
        end else begin
          e8 = q8.pop_front();
          check("s8", 64'(b8.s), e8.s);
          check("c_out8", 64'(b8.c_out), 64'(e8.c));
          check("ovf8", 64'(b8.ovf), 64'(e8.v));
          check("latency8", 64'(cyc - e8.cyc), 64'(NCYC8));
          last_s8 = e8.s; last_c8 = e8.c; last_v8 = e8.v;
        end
      end else begin
        check("hold8", {55'd0, b8.s, b8.c_out, b8.ovf},
              {55'd0, last_s8[7:0], last_c8, last_v8});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   bc;
    logic rs;
    logic [63:0] rx, ry;

    vecs[0] = '{1'b0, 64'd9,  64'd0, 64'd9,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'd15, 64'd1, 64'd0,  1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'd7,  64'd1, 64'd8,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 64'd3,  64'd5, 64'd14, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 64'd8,  64'd1, 64'd7,  1'b1, 1'b1};
    for (int i = 5; i < 8; i++) begin
      rs = 1'($urandom);
      rx = 64'($urandom_range(0, 15));
      ry = 64'($urandom_range(0, 15));
      e  = model(4, rs, rx, ry);
      vecs[i] = '{rs, rx, ry, e.s, e.c, e.v};
    end

    b4.start = 1'b0; b4.sub = 1'b0; b4.x = '0; b4.y = '0;
    b8.start = 1'b0; b8.sub = 1'b0; b8.x = '0; b8.y = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset acts before any clock edge.
    check("rst_busy4", 64'(b4.busy), 64'd0);
    check("rst_done4", 64'(b4.done), 64'd0);
    check("rst_s4", 64'(b4.s), 64'd0);
    check("rst_c4", 64'(b4.c_out), 64'd0);
    check("rst_ovf4", 64'(b4.ovf), 64'd0);
    check("rst_busy8", 64'(b8.busy), 64'd0);
    check("rst_done8", 64'(b8.done), 64'd0);
    check("rst_s8", 64'(b8.s), 64'd0);
    #11 rst_n = 1'b1;

    // Table vectors on the bit-serial instance; first one lands on the first edge after reset.
    for (int i = 0; i < 8; i++) begin
      e.s = vecs[i].s; e.c = vecs[i].c; e.v = vecs[i].v; e.cyc = 0;
      drive(4, vecs[i].sub, vecs[i].x, vecs[i].y, e);
      wait_drain(4, bc);
      check("busy_cycles4", 64'(bc), 64'(NCYC4));
    end

    // Start held high on the nibble-serial instance: a new op every NCYC8+1 cycles.
    b8.sub = 1'b0; b8.x = 8'd200; b8.y = 8'd100; b8.start = 1'b1;
    @(posedge clk); #1;
    e.s = 64'd44; e.c = 1'b1; e.v = 1'b0; e.cyc = cyc;
    q8.push_back(e);
    b8.sub = 1'b1; b8.x = 8'd16; b8.y = 8'd32;
    repeat (NCYC8) @(posedge clk);
    @(posedge clk); #1;
    e = model(8, 1'b1, 64'd16, 64'd32); e.cyc = cyc;
    q8.push_back(e);
    b8.sub = 1'b0; b8.x = 8'd127; b8.y = 8'd1;
    repeat (NCYC8) @(posedge clk);
    @(posedge clk); #1;
    e = model(8, 1'b0, 64'd127, 64'd1); e.cyc = cyc;
    q8.push_back(e);
    b8.start = 1'b0;
    wait_drain(8, bc);
    check("busy_cycles8", 64'(bc), 64'(NCYC8));

    // A second start two cycles into RUN must be ignored.
    drive(4, 1'b0, 64'd5, 64'd6, model(4, 1'b0, 64'd5, 64'd6));
    @(posedge clk);
    @(posedge clk); #1;
    b4.sub = 1'b1; b4.x = 4'd3; b4.y = 4'd3; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    wait_drain(4, bc);
    repeat (4) @(negedge clk);

    // Half-cycle reset pulse mid-RUN aborts the operation.
    drive(4, 1'b0, 64'd12, 64'd3, model(4, 1'b0, 64'd12, 64'd3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy4", 64'(b4.busy), 64'd0);
    check("midrst_done4", 64'(b4.done), 64'd0);
    check("midrst_s4", 64'(b4.s), 64'd0);
    check("midrst_c4", 64'(b4.c_out), 64'd0);
    check("midrst_ovf4", 64'(b4.ovf), 64'd0);
    check("midrst_s8", 64'(b8.s), 64'd0);
    q4.delete();
    q8.delete();
    last_s4 = '0; last_c4 = 1'b0; last_v4 = 1'b0;
    last_s8 = '0; last_c8 = 1'b0; last_v8 = 1'b0;
    #4 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    drive(4, 1'b1, 64'd2, 64'd9, model(4, 1'b1, 64'd2, 64'd9));
    wait_drain(4, bc);
    check("busy_cycles_after_rst4", 64'(bc), 64'(NCYC4));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aduna_seriala.md
ADUNA_SERIALA -- requirements
Module: aduna_seriala

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 1: bits added per clock cycle; SHALL divide WIDTH exactly, otherwise elaboration fails.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled at a rising edge.
REQ-006 sub  input  1  mode, sampled with start: 0 = x+y, 1 = x-y.
REQ-007 x  input  WIDTH  first operand, unsigned or two's complement, sampled with start.
REQ-008 y  input  WIDTH  second operand, sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse: s, c_out and ovf are newly valid.
REQ-011 s  output  WIDTH  result, low WIDTH bits.
REQ-012 c_out  output  1  carry out of MSB; in subtract mode 1 = no borrow (x >= y unsigned).
REQ-013 ovf  output  1  signed two's-complement overflow of the operation.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE or DONE with start=1 at edge E0: latch x, y (y inverted if sub=1), carry register := sub, digit counter := 0, next state RUN.
REQ-016 IDLE or DONE with start=0: DONE -> IDLE, IDLE stays IDLE.
REQ-017 In RUN, each edge adds the next DIGIT bits LSB-first with the carry register, stores the partial sum internally and updates carry; counter increments.
REQ-018 After NCYC = WIDTH/DIGIT RUN edges (edges E1..ENCYC), edge ENCYC SHALL load s, c_out, ovf and enter DONE; done = 1 for exactly that following cycle.
REQ-019 Latency start-edge to done high: NCYC cycles; back-to-back throughput: one operation per NCYC+1 cycles.
REQ-020 busy = 1 exactly while state is RUN; done = 1 exactly while state is DONE; busy and done never both high.
REQ-021 s, c_out, ovf SHALL hold the last completed result unchanged during RUN and IDLE; partial sums never visible on s.
REQ-022 start while in RUN SHALL be ignored; operands, mode and progress of the current operation unaffected.
REQ-023 x, y, sub changes outside the start edge SHALL have no effect.
REQ-024 Result arithmetic: s = (x + y) mod 2^WIDTH or (x + ~y + 1) mod 2^WIDTH; c_out = carry from bit WIDTH-1.
REQ-025 ovf = carry into MSB XOR carry out of MSB of the final digit.
REQ-026 Counter SHALL be ceil(log2(NCYC+1)) bits minimum and never wrap inside an operation.

Reset
REQ-027 rst_n = 0 SHALL immediately, without a clock edge, force state IDLE, busy = 0, done = 0, s = 0, c_out = 0, ovf = 0, counter = 0, carry = 0.
REQ-028 Reset asserted mid-RUN or during DONE SHALL abort the operation; no done pulse for it after release.
REQ-029 First edge after rst_n rises SHALL accept start normally.

Verification
REQ-030 WIDTH=4, DIGIT=1: x=9, y=0, sub=0 -> s=9, c_out=0, ovf=0; done high exactly 4 cycles after start edge, busy high for 4 cycles.
REQ-031 WIDTH=4, DIGIT=1: x=15, y=1, add -> s=0, c_out=1, ovf=0; x=7, y=1, add -> s=8, c_out=0, ovf=1.
REQ-032 WIDTH=4, DIGIT=1: x=3, y=5, sub=1 -> s=14, c_out=0, ovf=0; x=8, y=1, sub=1 -> s=7, c_out=1, ovf=1.
REQ-033 WIDTH=8, DIGIT=4: x=200, y=100, add -> s=44, c_out=1, done 2 cycles after start; start held high continuously -> new operation accepted in each DONE cycle, done every 3 cycles.
REQ-034 start pulsed again 2 cycles into RUN with different operands -> ignored, first result delivered on schedule, s unchanged before done.
REQ-035 rst_n low for half a cycle during RUN -> outputs 0 immediately, no done pulse afterwards; next start completes correctly.
